// File: rtl/mem_arbiter.sv
// Four-way shared-RAM arbiter: data class outranks instruction class, round-robin per core,
// grant held until the RAM reports ACCESS or the owner withdraws its request.
module mem_arbiter #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [1:0]          iREN,
  input  logic [1:0]          dREN,
  input  logic [1:0]          dWEN,
  input  logic [2*ADDR_W-1:0] iaddr,
  input  logic [2*ADDR_W-1:0] daddr,
  input  logic [2*WORD_W-1:0] dstore,
  input  logic                hold,
  input  logic [1:0]          ramstate,
  input  logic [WORD_W-1:0]   ramload,
  output logic [1:0]          iwait,
  output logic [1:0]          dwait,
  output logic [2*WORD_W-1:0] iload,
  output logic [2*WORD_W-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore
);

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       rr_q, rr_d;

  logic [1:0] dreq;
  logic       any_req;
  logic [1:0] win;
  logic       own_data;
  logic       own_core;
  logic       own_req;
  logic       access;

  assign dreq     = dREN | dWEN;
  assign any_req  = (|dreq) | (|iREN);
  assign own_data = owner_q[1];
  assign own_core = owner_q[0];
  assign own_req  = own_data ? dreq[own_core] : iREN[own_core];
  assign access   = (state_q == XFER) && (ramstate == RAM_ACCESS);

  // Fixed order: data[rr], data[!rr], instr[rr], instr[!rr].
  always_comb begin
    win = {1'b0, ~rr_q};
    if (dreq[rr_q]) begin
      win = {1'b1, rr_q};
    end else if (dreq[~rr_q]) begin
      win = {1'b1, ~rr_q};
    end else if (iREN[rr_q]) begin
      win = {1'b0, rr_q};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (!hold && any_req) begin
          state_d = XFER;
          owner_d = win;
        end
      end
      XFER: begin
        // A completed access takes precedence over a same-cycle retraction.
        if (ramstate == RAM_ACCESS) begin
          state_d = IDLE;
          rr_d    = ~own_core;
        end else if (!own_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    if (state_q == XFER) begin
      if (own_data) begin
        ramWEN   = dWEN[own_core];
        ramREN   = dREN[own_core] & ~dWEN[own_core];
        ramaddr  = own_core ? daddr[2*ADDR_W-1:ADDR_W] : daddr[ADDR_W-1:0];
        ramstore = own_core ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
      end else begin
        ramREN   = 1'b1;
        ramaddr  = own_core ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
      end
    end

    if (access) begin
      if (own_data) begin
        dwait[own_core] = 1'b0;
        if (own_core) dload[2*WORD_W-1:WORD_W] = ramload;
        else          dload[WORD_W-1:0]        = ramload;
      end else begin
        iwait[own_core] = 1'b0;
        if (own_core) iload[2*WORD_W-1:WORD_W] = ramload;
        else          iload[WORD_W-1:0]        = ramload;
      end
    end
  end

endmodule
